// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and small decode helpers used by the control logic.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    function automatic logic op_is_signed(input op_e op);
        return (op == MULT) || (op == DIV);
    endfunction

    function automatic logic op_is_div(input op_e op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between a requester (master) and the muldiv unit (slave).
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    // start is sampled only while busy is low; an accepted request ends with a
    // single done pulse, and hi/lo/divzero are valid from that pulse onward.
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             divzero;

    modport master (
        output start, op, a, b,
        input  hi, lo, busy, done, divzero
    );

    modport slave (
        input  start, op, a, b,
        output hi, lo, busy, done, divzero
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the sequential datapath: a radix-2 shift-add multiply step
// or a restoring shift-subtract divide step on a shared 2*WIDTH accumulator.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o
);
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        acc_hi = acc_i[2*WIDTH-1:WIDTH];
        acc_lo = acc_i[WIDTH-1:0];
        // Multiply: high half accumulates the multiplicand, multiplier shifts out of the low half.
        sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_i} : '0);
        // Divide: high half is the partial remainder, dividend bits shift in from the low half
        // while quotient bits shift in at the bottom.
        trial  = {acc_hi, acc_lo[WIDTH-1]};
        fits   = (trial >= {1'b0, opnd_i});
        diff   = trial[WIDTH-1:0] - opnd_i;
        acc_o  = '0;
        if (is_div_i) begin
            if (fits) begin
                acc_o = {diff, acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {trial[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = {sum, acc_lo[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Sequential MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers;
// magnitudes are iterated one bit per cycle and signs are fixed up at the end.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus,
    output state_e        dbg_state_o
);
    state_e             state_q;
    logic [CNTW-1:0]    cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] fixed;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               is_div_q;
    logic               qneg_q;
    logic               rneg_q;
    logic               bypass_q;
    logic               busy_q;
    logic               done_q;
    logic               dz_q;

    op_e                op_in;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        op_in = op_e'(bus.op);
        sa    = op_is_signed(op_in) & bus.a[WIDTH-1];
        sb    = op_is_signed(op_in) & bus.b[WIDTH-1];
        a_mag = sa ? -bus.a : bus.a;
        b_mag = sb ? -bus.b : bus.b;
    end

    // Sign correction; the MIN/-1 quotient wraps back to MIN by modulo negation.
    always_comb begin
        prod  = qneg_q ? -acc_q : acc_q;
        quot  = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        fixed = prod;
        if (bypass_q) begin
            fixed = acc_q;
        end else if (is_div_q) begin
            fixed = {rem, quot};
        end
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (acc_step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            bypass_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        case (op_in)
                            MTHI: begin
                                hi_q   <= bus.a;
                                done_q <= 1'b1;
                                dz_q   <= 1'b0;
                            end
                            MTLO: begin
                                lo_q   <= bus.a;
                                done_q <= 1'b1;
                                dz_q   <= 1'b0;
                            end
                            MULT, MULTU, DIV, DIVU: begin
                                busy_q   <= 1'b1;
                                is_div_q <= op_is_div(op_in);
                                if (op_is_div(op_in) && (bus.b == '0)) begin
                                    // Divide by zero skips iteration: hi=a, lo=all ones.
                                    state_q  <= FIX;
                                    acc_q    <= {bus.a, {WIDTH{1'b1}}};
                                    bypass_q <= 1'b1;
                                    qneg_q   <= 1'b0;
                                    rneg_q   <= 1'b0;
                                    dz_q     <= 1'b1;
                                end else begin
                                    state_q  <= RUN;
                                    cnt_q    <= CNTW'(WIDTH);
                                    bypass_q <= 1'b0;
                                    qneg_q   <= sa ^ sb;
                                    rneg_q   <= sa;
                                    dz_q     <= 1'b0;
                                    if (op_is_div(op_in)) begin
                                        acc_q  <= {{WIDTH{1'b0}}, a_mag};
                                        opnd_q <= b_mag;
                                    end else begin
                                        acc_q  <= {{WIDTH{1'b0}}, b_mag};
                                        opnd_q <= a_mag;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNTW'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    {hi_q, lo_q} <= fixed;
                    done_q       <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.divzero = dz_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit at WIDTH=32 and WIDTH=8 with a
// scoreboard queue per instance and a monitor that checks every done pulse.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        string       nm;
        logic [63:0] hilo;
        logic        dz;
        int          lat;
        longint      t0;
    } exp_t;

    logic   clk;
    logic   reset;
    state_e dbg32;
    state_e dbg8;
    int     n_tests = 0;
    int     n_fail  = 0;
    exp_t   exp32_q[$];
    exp_t   exp8_q[$];

    muldiv_unit_if #(.WIDTH(32)) bus32 ();
    muldiv_unit_if #(.WIDTH(8))  bus8 ();

    muldiv_unit #(.WIDTH(32)) u_dut32 (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus32),
        .dbg_state_o (dbg32)
    );

    muldiv_unit #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus8),
        .dbg_state_o (dbg8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitors: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus32.done === 1'b1) begin
            if (exp32_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL done32: unexpected done pulse, hi=0x%0h lo=0x%0h, expected no pulse",
                         bus32.hi, bus32.lo);
            end else begin
                exp_t e;
                e = exp32_q.pop_front();
                chk({e.nm, "_hilo"}, {bus32.hi, bus32.lo}, e.hilo);
                chk({e.nm, "_divzero"}, 64'(bus32.divzero), 64'(e.dz));
                chk({e.nm, "_latency"}, 64'(($time - e.t0 + 5) / 10), 64'(e.lat));
            end
        end
    end

    always @(negedge clk) begin
        if (bus8.done === 1'b1) begin
            if (exp8_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL done8: unexpected done pulse, hi=0x%0h lo=0x%0h, expected no pulse",
                         bus8.hi, bus8.lo);
            end else begin
                exp_t e;
                e = exp8_q.pop_front();
                chk({e.nm, "_hilo"}, 64'({bus8.hi, bus8.lo}), e.hilo);
                chk({e.nm, "_divzero"}, 64'(bus8.divzero), 64'(e.dz));
                chk({e.nm, "_latency"}, 64'(($time - e.t0 + 5) / 10), 64'(e.lat));
            end
        end
    end

    // Called between edges; start is held for exactly one rising edge.
    task automatic issue32(input string nm, input logic [2:0] o, input logic [31:0] av,
                           input logic [31:0] bv, input logic [63:0] ehl, input logic edz,
                           input int lat, input bit track);
        exp_t e;
        bus32.start = 1'b1;
        bus32.op    = o;
        bus32.a     = av;
        bus32.b     = bv;
        @(posedge clk);
        if (track) begin
            e.nm = nm; e.hilo = ehl; e.dz = edz; e.lat = lat; e.t0 = $time;
            exp32_q.push_back(e);
        end
        @(negedge clk);
        #1;
        bus32.start = 1'b0;
    endtask

    task automatic issue8(input string nm, input logic [2:0] o, input logic [7:0] av,
                          input logic [7:0] bv, input logic [15:0] ehl, input logic edz,
                          input int lat);
        exp_t e;
        bus8.start = 1'b1;
        bus8.op    = o;
        bus8.a     = av;
        bus8.b     = bv;
        @(posedge clk);
        e.nm = nm; e.hilo = 64'(ehl); e.dz = edz; e.lat = lat; e.t0 = $time;
        exp8_q.push_back(e);
        @(negedge clk);
        #1;
        bus8.start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 100; i++) begin
            if (!bus32.busy && !bus8.busy && exp32_q.size() == 0 && exp8_q.size() == 0) return;
            @(negedge clk);
            #1;
        end
        n_tests++;
        n_fail++;
        $display("FAIL timeout_%s: still busy/pending after 100 cycles, expected done", nm);
    endtask

    initial begin
        reset = 1'b0;
        bus32.start = 1'b0; bus32.op = 3'd0; bus32.a = '0; bus32.b = '0;
        bus8.start  = 1'b0; bus8.op  = 3'd0; bus8.a  = '0; bus8.b  = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_hi", 64'(bus32.hi), 64'h0);
        chk("rst_lo", 64'(bus32.lo), 64'h0);
        chk("rst_busy", 64'(bus32.busy), 64'h0);
        chk("rst_done", 64'(bus32.done), 64'h0);
        chk("rst_divzero", 64'(bus32.divzero), 64'h0);
        chk("rst_state", 64'(dbg32), 64'(IDLE));
        reset = 1'b1;

        issue32("mult_m3x7", MULT, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 34, 1);
        wait_idle("mult_m3x7");
        issue32("div_m7d2", DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 34, 1);
        wait_idle("div_m7d2");
        issue32("divu_7d2", DIVU, 32'd7, 32'd2, 64'h00000001_00000003, 1'b0, 34, 1);
        wait_idle("divu_7d2");
        issue32("divu_5d0", DIVU, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b1, 2, 1);
        wait_idle("divu_5d0");
        issue32("multu_2x3", MULTU, 32'd2, 32'd3, 64'h00000000_00000006, 1'b0, 34, 1);
        wait_idle("multu_2x3");

        // Second start mid-RUN must be ignored; hi/lo hold until completion.
        issue32("multu_mid", MULTU, 32'h12345678, 32'h10, 64'h00000001_23456780, 1'b0, 34, 1);
        repeat (4) @(negedge clk);
        #1;
        chk("mid_busy", 64'(bus32.busy), 64'h1);
        chk("mid_state", 64'(dbg32), 64'(RUN));
        chk("mid_hold", {bus32.hi, bus32.lo}, 64'h00000000_00000006);
        bus32.start = 1'b1; bus32.op = MTHI; bus32.a = 32'hDEAD; bus32.b = 32'h0;
        @(negedge clk);
        #1;
        bus32.start = 1'b0;
        wait_idle("multu_mid");

        issue32("div_min_m1", DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 34, 1);
        wait_idle("div_min_m1");
        issue32("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 34, 1);
        wait_idle("multu_max");
        issue32("mult_minmin", MULT, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, 34, 1);
        wait_idle("mult_minmin");
        issue32("div_7dm2", DIV, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 34, 1);
        wait_idle("div_7dm2");
        issue32("div_m4d0", DIV, 32'hFFFFFFFC, 32'd0, 64'hFFFFFFFC_FFFFFFFF, 1'b1, 2, 1);
        wait_idle("div_m4d0");
        issue32("mthi_aa", MTHI, 32'hAA, 32'd0, 64'h000000AA_FFFFFFFF, 1'b0, 1, 1);
        wait_idle("mthi_aa");

        // Abandon a divide mid-RUN with an asynchronous reset.
        issue32("div_abort", DIV, 32'd100, 32'd3, 64'h0, 1'b0, 0, 0);
        repeat (9) @(negedge clk);
        #1;
        chk("abort_busy_before", 64'(bus32.busy), 64'h1);
        reset = 1'b0;
        #1;
        chk("abort_hi", 64'(bus32.hi), 64'h0);
        chk("abort_lo", 64'(bus32.lo), 64'h0);
        chk("abort_busy", 64'(bus32.busy), 64'h0);
        chk("abort_done", 64'(bus32.done), 64'h0);
        chk("abort_state", 64'(dbg32), 64'(IDLE));
        @(negedge clk);
        #1;
        chk("abort_done_held", 64'(bus32.done), 64'h0);
        reset = 1'b1;
        issue32("mtlo_55", MTLO, 32'h55, 32'd0, 64'h00000000_00000055, 1'b0, 1, 1);
        wait_idle("mtlo_55");

        issue8("w8_mult", MULT, 8'h80, 8'hFF, 16'h0080, 1'b0, 10);
        wait_idle("w8_mult");
        issue8("w8_div", DIV, 8'h80, 8'hFF, 16'h0080, 1'b0, 10);
        wait_idle("w8_div");
        issue8("w8_multu", MULTU, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 10);
        wait_idle("w8_multu");
        issue8("w8_divu", DIVU, 8'hC8, 8'h07, 16'h041C, 1'b0, 10);
        wait_idle("w8_divu");
        issue8("w8_divu0", DIVU, 8'h10, 8'h00, 16'h10FF, 1'b1, 2);
        wait_idle("w8_divu0");

        repeat (3) @(negedge clk);
        chk("queues_empty", 64'(exp32_q.size() + exp8_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
